// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared types and constants for the ALU program sequencer.
//             Holds the opcode constants, the sequencer state encoding and
//             the stored program entry layout.
//  Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    // Opcodes understood by the downstream accumulator ALU
    localparam logic [2:0] OPC_NOP  = 3'b000;
    localparam logic [2:0] OPC_LOAD = 3'b001;
    localparam logic [2:0] OPC_ADD  = 3'b010;
    localparam logic [2:0] OPC_SUB  = 3'b011;

    // Width of the operand field held in a program entry (ALU operand width)
    localparam int c_OPND_W = 7;

    // Sequencer states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One stored instruction; the opcode is kept verbatim, never decoded
    typedef struct packed {
        logic [2:0]          opcode;
        logic [c_OPND_W-1:0] operand;
    } entry_t;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_seq_mem.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_mem
//  Purpose  : DEPTH-entry program store. Synchronous write, asynchronous
//             read. The array itself carries no reset; the sequencer's
//             count register decides which entries are meaningful.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq_mem
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  entry_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output entry_t        o_rdata
);

    entry_t r_mem [DEPTH];

    // Store an accepted record at the write pointer
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : alu_seq_mem
`default_nettype wire

// File: rtl/alu_seq_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_feeder
//  Purpose  : Records up to DEPTH instructions and replays them one per
//             cycle (or one per step pulse) into the accumulator ALU, once
//             or looping. Drives NOP with operand 0 whenever not issuing.
//  Options  : SEQ_STEP_EN - adds input 'step'; in RUN an entry is issued
//             only on cycles where step is high.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq_feeder
    import alu_seq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int OPND_W = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    input  logic [2:0]             cmd_opcode,
    input  logic [OPND_W-1:0]      cmd_operand,
    output logic                   cmd_ready,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   clear,
    input  logic                   loop_en,
`ifdef SEQ_STEP_EN
    input  logic                   step,
`endif
    output logic [2:0]             alu_opcode,
    output logic [OPND_W-1:0]      alu_operand,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    state_t              r_state;
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_CW-1:0]     r_count;
    logic [2:0]          r_opcode;
    logic [OPND_W-1:0]   r_operand;
    logic                r_done;
`ifdef SEQ_STEP_EN
    logic                r_fin;     // last entry issued, NOP/done due next edge
`endif

    logic                w_rec;
    logic                w_last;
    logic [c_AW-1:0]     w_raddr;
    entry_t              w_wdata;
    entry_t              w_rdata;

    assign cmd_ready = (r_state == IDLE) && (r_count < c_CW'(DEPTH)) && !start && !clear;
    assign w_rec     = cmd_valid && cmd_ready;
    assign w_wdata   = '{opcode: cmd_opcode, operand: c_OPND_W'(cmd_operand)};

    // r_rd_ptr names the entry on the outputs (per-cycle mode) or the next
    // entry to issue (step mode); either way it is the final one when it
    // equals count-1.
    assign w_last = ((c_CW'(r_rd_ptr) + c_CW'(1)) == r_count);

`ifdef SEQ_STEP_EN
    assign w_raddr = r_rd_ptr;
`else
    // Look one entry ahead so the next output can be registered without a
    // bubble; address 0 serves both the start and the loop wrap.
    assign w_raddr = (r_state == RUN && !w_last) ? r_rd_ptr + c_AW'(1) : '0;
`endif

    alu_seq_mem #(
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_rec),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Sequencer FSM, pointers, count and registered ALU outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_opcode  <= OPC_NOP;
            r_operand <= '0;
            r_done    <= 1'b0;
`ifdef SEQ_STEP_EN
            r_fin     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_rec) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
                r_count  <= r_count + c_CW'(1);
            end
            if (clear) begin
                r_state   <= IDLE;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_opcode  <= OPC_NOP;
                r_operand <= '0;
`ifdef SEQ_STEP_EN
                r_fin     <= 1'b0;
`endif
            end else if (stop) begin
                r_state   <= IDLE;
                r_opcode  <= OPC_NOP;
                r_operand <= '0;
`ifdef SEQ_STEP_EN
                r_fin     <= 1'b0;
`endif
            end else if (r_state == IDLE) begin
                if (start) begin
                    if (r_count != '0) begin
                        r_state  <= RUN;
                        r_rd_ptr <= '0;
`ifndef SEQ_STEP_EN
                        // Entry 0 goes out in the first RUN cycle
                        r_opcode  <= w_rdata.opcode;
                        r_operand <= OPND_W'(w_rdata.operand);
`endif
                    end else begin
                        // Empty program: nothing to play, report completion
                        r_done <= 1'b1;
                    end
                end
            end else begin
`ifdef SEQ_STEP_EN
                if (r_fin) begin
                    r_state   <= IDLE;
                    r_opcode  <= OPC_NOP;
                    r_operand <= '0;
                    r_done    <= 1'b1;
                    r_fin     <= 1'b0;
                end else if (step) begin
                    r_opcode  <= w_rdata.opcode;
                    r_operand <= OPND_W'(w_rdata.operand);
                    if (w_last) begin
                        r_rd_ptr <= '0;
                        r_fin    <= !loop_en;
                    end else begin
                        r_rd_ptr <= r_rd_ptr + c_AW'(1);
                    end
                end else begin
                    r_opcode  <= OPC_NOP;
                    r_operand <= '0;
                end
`else
                if (w_last && !loop_en) begin
                    r_state   <= IDLE;
                    r_opcode  <= OPC_NOP;
                    r_operand <= '0;
                    r_done    <= 1'b1;
                end else begin
                    r_rd_ptr  <= w_last ? '0 : r_rd_ptr + c_AW'(1);
                    r_opcode  <= w_rdata.opcode;
                    r_operand <= OPND_W'(w_rdata.operand);
                end
`endif
            end
        end
    end

    assign alu_opcode  = r_opcode;
    assign alu_operand = r_operand;
    assign busy        = (r_state == RUN);
    assign done        = r_done;
    assign count       = r_count;

endmodule : alu_seq_feeder
`default_nettype wire

// File: tb/tb_alu_seq_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq_feeder
//  Purpose  : Directed self-checking bench for alu_seq_feeder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq_feeder;

    localparam int DEPTH  = 8;
    localparam int OPND_W = 7;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cmd_valid = 1'b0;
    logic [2:0]             cmd_opcode = '0;
    logic [OPND_W-1:0]      cmd_operand = '0;
    logic                   cmd_ready;
    logic                   start = 1'b0;
    logic                   stop = 1'b0;
    logic                   clear = 1'b0;
    logic                   loop_en = 1'b0;
`ifdef SEQ_STEP_EN
    logic                   step = 1'b0;
`endif
    logic [2:0]             alu_opcode;
    logic [OPND_W-1:0]      alu_operand;
    logic                   busy;
    logic                   done;
    logic [$clog2(DEPTH):0] count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] acc;
    logic       carry;
    logic [2:0] exp_op  [8];
    logic [6:0] exp_opd [8];

    alu_seq_feeder #(.DEPTH(DEPTH), .OPND_W(OPND_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_opcode  (cmd_opcode),
        .cmd_operand (cmd_operand),
        .cmd_ready   (cmd_ready),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .loop_en     (loop_en),
`ifdef SEQ_STEP_EN
        .step        (step),
`endif
        .alu_opcode  (alu_opcode),
        .alu_operand (alu_operand),
        .busy        (busy),
        .done        (done),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic record(input logic [2:0] op, input logic [6:0] v);
        cmd_valid   = 1'b1;
        cmd_opcode  = op;
        cmd_operand = v;
        tick();
        cmd_valid   = 1'b0;
    endtask

    task automatic expect_alu(input string tag, input logic [2:0] op, input logic [6:0] v);
        check({tag, ".op"},   32'(alu_opcode),  32'(op));
        check({tag, ".opnd"}, 32'(alu_operand), 32'(v));
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Tiny 7-bit accumulator model fed from the observed ALU inputs
    task automatic acc_apply();
        case (alu_opcode)
            3'b001: begin acc = alu_operand; carry = 1'b0; end
            3'b010: {carry, acc} = {1'b0, acc} + {1'b0, alu_operand};
            3'b011: {carry, acc} = {1'b0, acc} - {1'b0, alu_operand};
            default: ;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        acc = '0;
        carry = 1'b0;
        // ---------------- reset state
        tick(); tick();
        rst_n = 1'b1;
        expect_alu("rst", 3'd0, 7'd0);
        check("rst.busy",  32'(busy),  32'd0);
        check("rst.done",  32'(done),  32'd0);
        check("rst.count", 32'(count), 32'd0);
        check("rst.ready", 32'(cmd_ready), 32'd1);

        // ---------------- LOAD 5, ADD 3, ADD 120 single pass
        record(3'b001, 7'd5);
        record(3'b010, 7'd3);
        record(3'b010, 7'd120);
        check("p1.count", 32'(count), 32'd3);
        start = 1'b1; tick(); start = 1'b0;
        expect_alu("p1.e0", 3'b001, 7'd5);
        check("p1.busy", 32'(busy), 32'd1);
        acc_apply(); tick();
        expect_alu("p1.e1", 3'b010, 7'd3);
        acc_apply(); tick();
        expect_alu("p1.e2", 3'b010, 7'd120);
        check("p1.done_early", 32'(done), 32'd0);
        acc_apply(); tick();
        expect_alu("p1.end", 3'd0, 7'd0);
        check("p1.done", 32'(done), 32'd1);
        check("p1.busy_end", 32'(busy), 32'd0);
        check("p1.acc",   32'(acc),   32'd0);
        check("p1.carry", 32'(carry), 32'd1);
        tick();
        check("p1.done_once", 32'(done), 32'd0);

        // ---------------- fill to DEPTH, ninth record dropped
        pulse_clear();
        check("full.clr_count", 32'(count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            exp_op[i]  = 3'((i % 3) + 1);
            exp_opd[i] = 7'(10 + i);
        end
        for (int i = 0; i < 7; i++) record(exp_op[i], exp_opd[i]);
        check("full.ready7", 32'(cmd_ready), 32'd1);
        record(exp_op[7], exp_opd[7]);
        check("full.count8", 32'(count), 32'd8);
        check("full.ready8", 32'(cmd_ready), 32'd0);
        record(3'b011, 7'd99);
        check("full.count9", 32'(count), 32'd8);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_alu($sformatf("full.e%0d", i), exp_op[i], exp_opd[i]);
            tick();
        end
        expect_alu("full.end", 3'd0, 7'd0);
        check("full.done", 32'(done), 32'd1);

        // ---------------- looping A,B until stop
        pulse_clear();
        record(3'b011, 7'd7);   // A
        record(3'b010, 7'd9);   // B
        loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) expect_alu($sformatf("loop.%0d", i), 3'b011, 7'd7);
            else            expect_alu($sformatf("loop.%0d", i), 3'b010, 7'd9);
            check($sformatf("loop.done%0d", i), 32'(done), 32'd0);
            if (i < 4) tick();
        end
        stop = 1'b1; tick(); stop = 1'b0;
        loop_en = 1'b0;
        expect_alu("stop.nop", 3'd0, 7'd0);
        check("stop.done",  32'(done),  32'd0);
        check("stop.busy",  32'(busy),  32'd0);
        check("stop.count", 32'(count), 32'd2);
        tick();
        check("stop.done2", 32'(done), 32'd0);

        // ---------------- start with empty program; start blocks record
        pulse_clear();
        start = 1'b1; cmd_valid = 1'b1; cmd_opcode = 3'b001; cmd_operand = 7'd1;
        #1;
        check("empty.ready", 32'(cmd_ready), 32'd0);
        tick();
        start = 1'b0; cmd_valid = 1'b0;
        check("empty.busy",  32'(busy),  32'd0);
        check("empty.done",  32'(done),  32'd1);
        check("empty.count", 32'(count), 32'd0);
        expect_alu("empty", 3'd0, 7'd0);
        tick();
        check("empty.done_once", 32'(done), 32'd0);

        // ---------------- clear mid-RUN at entry 1 of 4
        for (int i = 0; i < 4; i++) record(3'b010, 7'(20 + i));
        start = 1'b1; tick(); start = 1'b0;
        expect_alu("clr.e0", 3'b010, 7'd20);
        tick();
        expect_alu("clr.e1", 3'b010, 7'd21);
        pulse_clear();
        expect_alu("clr.nop", 3'd0, 7'd0);
        check("clr.count", 32'(count), 32'd0);
        check("clr.done",  32'(done),  32'd0);
        check("clr.busy",  32'(busy),  32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("clr.restart_busy", 32'(busy), 32'd0);
        check("clr.restart_done", 32'(done), 32'd1);

        // ---------------- reset mid-RUN loses the program
        record(3'b001, 7'd33);
        record(3'b010, 7'd44);
        loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        expect_alu("rrun.e1", 3'b010, 7'd44);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        loop_en = 1'b0;
        expect_alu("rrun.nop", 3'd0, 7'd0);
        check("rrun.busy",  32'(busy),  32'd0);
        check("rrun.count", 32'(count), 32'd0);

`ifdef SEQ_STEP_EN
        // ---------------- step-gated issue, step every 3rd cycle
        record(3'b001, 7'd1);
        record(3'b010, 7'd2);
        record(3'b011, 7'd3);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step = (i % 3 == 2);
            tick();
            step = 1'b0;
            if (i % 3 == 2) expect_alu($sformatf("step.%0d", i), 3'((i / 3) + 1), 7'((i / 3) + 1));
            else            expect_alu($sformatf("step.%0d", i), 3'd0, 7'd0);
            check($sformatf("step.done%0d", i), 32'(done), 32'd0);
        end
        tick();
        expect_alu("step.end", 3'd0, 7'd0);
        check("step.done", 32'(done), 32'd1);
        check("step.busy", 32'(busy), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_seq_feeder
`default_nettype wire

// File: doc/alu_seq_feeder.md
# alu_seq_feeder

Program buffer and sequencer directly upstream of the 7-bit accumulator ALU. It records up to DEPTH instructions (3-bit opcode plus 7-bit operand) from the switch/IO front end. On command, it replays them one per cycle into the ALU's opcode and operand inputs, either once or looping. When idle, it drives NOP so the accumulator holds its value.

## Interface
Parameters:
- DEPTH, 8, number of program entries; power of two, 2..16
- OPND_W, 7, operand width; matches the ALU operand

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  record request for one instruction
- cmd_opcode  in  3  opcode to record
- cmd_operand  in  OPND_W  operand to record
- cmd_ready  out  1  record accepted this cycle when cmd_valid is also 1
- start  in  1  one-cycle pulse that begins playback at entry 0
- stop  in  1  abort playback; program is kept
- clear  in  1  abort playback and empty the program
- loop_en  in  1  wrap to entry 0 after the last entry
- alu_opcode  out  3  registered opcode to the ALU
- alu_operand  out  OPND_W  registered operand to the ALU
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when a non-looping pass completes
- count  out  $clog2(DEPTH)+1  number of recorded entries

## Operation
- States are IDLE and RUN. Reset puts the block in IDLE.
- Reset values: count=0, wr_ptr=0, rd_ptr=0, alu_opcode=000 (NOP), alu_operand=0, busy=0, done=0.
- Input priority each cycle is clear > stop > start > record.
- cmd_ready = (state==IDLE) && (count<DEPTH) && !start && !clear.
  - Records made while full or during RUN are dropped.
  - A record accepted at count==DEPTH-1 makes count=DEPTH. cmd_ready then falls.
- IDLE with start=1 and count>0:
  - Go to RUN with rd_ptr=0.
- IDLE with start=1 and count==0:
  - Stay in IDLE.
  - done pulses on the next cycle. Outputs stay NOP.
- RUN, each cycle:
  - Register entry[rd_ptr] onto the alu_* outputs, then increment rd_ptr.
- RUN, when the issued entry is index count-1:
  - If loop_en=1 in that cycle, set rd_ptr=0 and stay in RUN.
  - If loop_en=0, go to IDLE. done pulses in the cycle the outputs return to NOP.
- stop in RUN: go to IDLE. Outputs are NOP from the next cycle. No done pulse. count is unchanged.
- clear in any state: go to IDLE and set count=0, wr_ptr=0, rd_ptr=0. Outputs are NOP next cycle. No done pulse.
- Every output is NOP with operand 0 whenever the block is not issuing an entry.
- Recorded opcodes are stored verbatim and are not decoded. The ALU treats unimplemented codes as NOP.

## Timing
- start sampled at cycle t: entry k appears on alu_* at cycle t+1+k. busy is high from t+1.
- Non-looping pass of N entries: NOP and done=1 at cycle t+1+N. busy is low from t+1+N.
- Looping pass: entry 0 follows entry N-1 with no bubble.
- A record accepted at cycle t is visible in count at t+1. It is replayable by a start at t+1.
- stop or clear at cycle t: the alu_* value from t is the last issued entry. NOP appears at t+1.
- Reset asserted mid-RUN gives NOP and IDLE on the next edge, and the program is lost.

## Configuration
- SEQ_STEP_EN, when defined, adds port step (in, 1).
  - In RUN, an entry is issued only on cycles where step=1. Other cycles output NOP, and rd_ptr holds.
  - done pulses in the cycle after the step that issued the last entry.
- Without SEQ_STEP_EN, the step port does not exist and one entry is issued every RUN cycle.

## Structure
- Package alu_seq_pkg contains:
  - opcode constants OPC_NOP=000, OPC_LOAD=001, OPC_ADD=010, OPC_SUB=011
  - the state enum {IDLE, RUN}
  - the entry struct {opcode, operand}
- Sub-module alu_seq_mem is the DEPTH-entry register file: synchronous write, asynchronous read, and no reset on the storage array.
- Top level contains the FSM, the pointers, count, and the output registers.

## Test plan
- Reset, then record LOAD 5, ADD 3, ADD 120, then start with loop_en=0.
  - The ALU inputs read 001/5, 010/3, 010/120 on consecutive cycles, then NOP with done=1.
  - Accumulator=0, carry=1.
- Record 8 entries, then a ninth with cmd_valid=1: cmd_ready=0, count stays 8, and the ninth is not replayed.
- loop_en=1 with 2 entries: the pattern A,B,A,B continues until stop. Stop gives NOP next cycle, no done, and count=2.
- start with count=0: busy stays 0, done pulses once, outputs stay NOP.
- clear mid-RUN at entry 1 of 4: NOP next cycle, count=0, no done. A later start behaves as the empty case.
- Under SEQ_STEP_EN, 3 entries and step pulsed every 3rd cycle: each entry appears only in step cycles, with NOP between, and done follows the third step.
